zeroriscy_fetch_fifo: RTL and testbench
=======================================

// Module: zeroriscy_fetch_fifo
// PURPOSE
//  Instruction prefetch queue between the instruction memory port and the IF stage.
//  - Issues sequential word fetches, tracks at most one outstanding transaction and buffers returned
//    words with their addresses in a DEPTH-entry FIFO.
//  - Delivers them to IF with a valid/ready handshake.
//  - On branch: flushes all buffered data and discards any in-flight response.
// PARAMETERS
//  DEPTH  3  FIFO entries (>=2); bounds buffered words plus outstanding requests
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  req_i           in   1   fetch enable; 0 = issue no new requests
//  branch_i        in   1   restart fetching at addr_i (flush)
//  addr_i          in   32  branch target; [1:0] ignored, word aligned
//  ready_i         in   1   IF consumes FIFO head this cycle
//  valid_o         out  1   FIFO head valid
//  rdata_o         out  32  FIFO head instruction word
//  addr_o          out  32  FIFO head word address
//  instr_req_o     out  1   memory request
//  instr_addr_o    out  32  memory request address, [1:0]=00
//  instr_gnt_i     in   1   memory grant; request accepted this cycle
//  instr_rvalid_i  in   1   read data valid; >=1 cycle after its gnt
//  instr_rdata_i   in   32  read data
//  busy_o          out  1   state!=IDLE or transaction outstanding
// BEHAVIOUR
//  Reset: instr_req_o=0, valid_o=0, busy_o=0, rdata_o=addr_o=0, FIFO empty, fetch_addr=0, state IDLE.
//  fetch_addr (32b) = next word to request.
//  - Increments by 4 on each gnt; wraps 0xFFFF_FFFC->0.
//  - Loaded with {addr_i[31:2],2'b00} on branch_i.
//  Credit rule: new request allowed only if req_i && (fifo_count + outstanding) < DEPTH.
//  FSM:
//   IDLE:
//    - Credit ok -> drive req, addr=fetch_addr -> WAIT_GNT (same-cycle req).
//   WAIT_GNT:
//    - instr_req_o=1 held until gnt.
//    - gnt -> WAIT_RVALID, fetch_addr+=4.
//    - branch_i while ungranted: instr_addr_o switches to new target the same cycle
//      (memory permits address change before grant).
//   WAIT_RVALID:
//    - instr_req_o=0.
//    - rvalid -> push {rdata, request addr} to FIFO.
//    - Next: WAIT_GNT if credit allows (req same cycle), else IDLE.
//   ABORTED:
//    - Entered on branch_i in WAIT_RVALID without rvalid.
//    - Next rvalid is dropped (no push); then -> WAIT_GNT/IDLE per credit, fetching new target.
//  Branch with rvalid in same cycle in WAIT_RVALID: data dropped, go straight to WAIT_GNT at new target.
//  branch_i priority:
//   - Overrides push/pop in same cycle; FIFO count -> 0, valid_o=0 next cycle.
//   - If req_i=1 and state IDLE, request issued same cycle at new target.
//  FIFO:
//   - valid_o = count!=0; registered output, no bypass.
//   - Latency rvalid -> valid_o = 1 cycle.
//   - Pop when valid_o && ready_i; push and pop same cycle allowed, count unchanged.
//   - Never overflows (credit rule).
//   - ready_i with valid_o=0 ignored.
//  req_i=0: no new requests; outstanding transaction still completes and is buffered.
//  Reset mid-transaction: state cleared; late rvalid after reset ignored
//  (outstanding=0 means drop).
//  gnt without req: ignored.
// TESTING
//  - Reset, req_i=1, branch_i@0x100, gnt immediate, rvalid+1:
//    -> instr_addr_o 0x100,0x104,0x108; valid_o 1 cycle after each rvalid; addr_o matches.
//  - ready_i=0 held, DEPTH=3:
//    -> exactly 3 grants, then instr_req_o=0 until a pop; one pop -> one new req.
//  - branch_i@0x200 in WAIT_RVALID, rvalid next cycle with 0xDEAD:
//    -> 0xDEAD never on rdata_o; next req addr 0x200.
//  - branch_i@0x300 while req pending without gnt:
//    -> instr_addr_o=0x300 same cycle, FIFO flushed, first delivered addr_o=0x300.
//  - fetch_addr 0xFFFF_FFFC granted -> next request 0x0000_0000.
//  - rst_n low mid WAIT_RVALID:
//    -> all outputs 0 asynchronously; stray rvalid after release not pushed.

Source files
------------

// File: rtl/zeroriscy_fetch_fifo.sv
// Instruction prefetch queue: issues sequential word fetches with one transaction in flight
// and buffers returned words with their addresses for the IF stage.
module zeroriscy_fetch_fifo #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, ABORTED} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   target;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [63:0]   mem_q [DEPTH];
  int            count_int;

  assign target    = {addr_i[31:2], 2'b00};
  assign count_int = int'(count_q);
  assign pop       = (count_q != '0) && ready_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
    end
  end

  // Output logic; a branch counts as a flush, so credit is free whenever branch_i is high.
  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      IDLE:        issue = req_i && (branch_i || count_int < DEPTH);
      WAIT_GNT:    issue = 1'b1;
      WAIT_RVALID: if (instr_rvalid_i) issue = req_i && (branch_i || count_int + 1 < DEPTH);
      ABORTED:     if (instr_rvalid_i) issue = req_i && (branch_i || count_int < DEPTH);
      default:     issue = 1'b0;
    endcase
    issue        = issue && rst_n;
    instr_req_o  = issue;
    instr_addr_o = rst_n ? (branch_i ? target : fetch_addr_q) : '0;
    busy_o       = (state_q != IDLE);
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = branch_i ? target : fetch_addr_q;
    req_addr_d   = req_addr_q;
    push         = 1'b0;
    unique case (state_q)
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          push    = !branch_i;
          state_d = IDLE;
        end else if (branch_i) begin
          state_d = ABORTED;
        end
      end
      ABORTED:  if (instr_rvalid_i) state_d = IDLE;
      default:  state_d = state_q;
    endcase
    if (issue) begin
      if (instr_gnt_i) begin
        state_d      = WAIT_RVALID;
        fetch_addr_d = instr_addr_o + 32'd4;
        req_addr_d   = instr_addr_o;
      end else begin
        state_d = WAIT_GNT;
      end
    end
  end

  // FIFO storage; entries hold {rdata, word address}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (branch_i) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {instr_rdata_i, req_addr_q};
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_q][63:32];
  assign addr_o  = mem_q[rd_q][31:0];

endmodule

// File: tb/tb_zeroriscy_fetch_fifo.sv
// Bench for zeroriscy_fetch_fifo: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_zeroriscy_fetch_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o;
  logic [31:0] rdata_o, addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  logic pend   = 1'b0;

  zeroriscy_fetch_fifo #(.DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req, br; logic [31:0] addr; logic rdy, gnt, rv; logic [31:0] rdata;
    logic e_req; logic [31:0] e_iaddr; logic e_valid; logic [31:0] e_rdata, e_addr; logic e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, br, input logic [31:0] addr, input logic rdy, gnt, rv,
                              input logic [31:0] rdata, input logic e_req, input logic [31:0] e_iaddr,
                              input logic e_valid, input logic [31:0] e_rdata, e_addr, input logic e_busy);
    vec_t v;
    v.req = req; v.br = br; v.addr = addr; v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_iaddr = e_iaddr; v.e_valid = e_valid; v.e_rdata = e_rdata;
    v.e_addr = e_addr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_i = 0; branch_i = 0; addr_i = '0; ready_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; idle_inputs(); pend = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle against a memory that grants at once and answers the next cycle.
  task automatic mem_cycle(input logic req, br, input logic [31:0] baddr, input logic rdy,
                           output logic granted);
    @(negedge clk);
    req_i = req; branch_i = br; addr_i = baddr; ready_i = rdy;
    instr_rvalid_i = pend; instr_rdata_i = 32'hC0DE_0000 + $urandom_range(0, 255);
    #1;
    instr_gnt_i = instr_req_o;
    granted = instr_req_o;
    pend = instr_req_o;
  endtask

  initial begin
    int grants;
    logic g;
    rst_n = 0; idle_inputs();
    #2;
    chk("rst_instr_req", {31'd0, instr_req_o}, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr_o", addr_o, 0);
    chk("rst_instr_addr", instr_addr_o, 0);
    @(negedge clk);
    rst_n = 1;

    //                req br addr          rdy gnt rv rdata      e_req e_iaddr       e_val e_rdata    e_addr        e_busy
    vecs.push_back(mk(1, 1, 32'h100,      0, 1, 0, 0,          1, 32'h100,      0, 0,         0,            0));
    vecs.push_back(mk(1, 0, 0,            0, 1, 1, 32'hA0,     1, 32'h104,      0, 0,         0,            1));
    vecs.push_back(mk(1, 0, 0,            0, 1, 1, 32'hA1,     1, 32'h108,      1, 32'hA0,    32'h100,      1));
    vecs.push_back(mk(1, 0, 0,            1, 1, 1, 32'hA2,     0, 0,            1, 32'hA0,    32'h100,      1));
    vecs.push_back(mk(1, 0, 0,            1, 0, 0, 0,          1, 32'h10C,      1, 32'hA1,    32'h104,      0));
    vecs.push_back(mk(1, 0, 0,            0, 1, 0, 0,          1, 32'h10C,      1, 32'hA2,    32'h108,      1));
    vecs.push_back(mk(1, 1, 32'h200,      0, 0, 0, 0,          0, 0,            1, 32'hA2,    32'h108,      1));
    vecs.push_back(mk(1, 0, 0,            0, 1, 1, 32'hDEAD,   1, 32'h200,      0, 0,         0,            1));
    vecs.push_back(mk(1, 0, 0,            0, 0, 1, 32'hB0,     1, 32'h204,      0, 0,         0,            1));
    vecs.push_back(mk(1, 1, 32'h303,      0, 0, 0, 0,          1, 32'h300,      1, 32'hB0,    32'h200,      1));
    vecs.push_back(mk(1, 0, 0,            0, 1, 0, 0,          1, 32'h300,      0, 0,         0,            1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 1, 32'hC0,     0, 0,            0, 0,         0,            1));
    vecs.push_back(mk(0, 0, 0,            1, 0, 0, 0,          0, 0,            1, 32'hC0,    32'h300,      0));
    vecs.push_back(mk(0, 0, 0,            0, 1, 0, 0,          0, 0,            0, 0,         0,            0));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFF, 0, 1, 0, 0,          1, 32'hFFFFFFFC, 0, 0,         0,            0));
    vecs.push_back(mk(1, 0, 0,            0, 0, 1, 32'hD0,     1, 32'h0,        0, 0,         0,            1));
    vecs.push_back(mk(1, 0, 0,            0, 0, 0, 0,          1, 32'h0,        1, 32'hD0,    32'hFFFFFFFC, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_i = vecs[i].req; branch_i = vecs[i].br; addr_i = vecs[i].addr; ready_i = vecs[i].rdy;
      instr_gnt_i = vecs[i].gnt; instr_rvalid_i = vecs[i].rv; instr_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_instr_req", i), {31'd0, instr_req_o}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_instr_addr", i), instr_addr_o, vecs[i].e_iaddr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].e_rdata);
        chk($sformatf("v%0d_addr_o", i), addr_o, vecs[i].e_addr);
      end
      chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, {31'd0, vecs[i].e_busy});
    end

    // Back-pressure: DEPTH grants, then one pop frees exactly one more request.
    do_reset();
    grants = 0;
    mem_cycle(1, 1, 32'h400, 0, g); grants += int'(g);
    for (int i = 0; i < 12; i++) begin
      mem_cycle(1, 0, 0, 0, g); grants += int'(g);
    end
    chk("credit_grants", grants, 3);
    chk("credit_req_low", {31'd0, instr_req_o}, 0);
    chk("credit_full_valid", {31'd0, valid_o}, 1);
    grants = 0;
    mem_cycle(1, 0, 0, 1, g); grants += int'(g);
    for (int i = 0; i < 10; i++) begin
      mem_cycle(1, 0, 0, 0, g); grants += int'(g);
    end
    chk("credit_after_pop", grants, 1);

    // Branch coinciding with rvalid in WAIT_RVALID: data dropped, refetch at new target.
    do_reset();
    @(negedge clk);
    req_i = 1; branch_i = 1; addr_i = 32'h500; instr_gnt_i = 1;
    @(negedge clk);
    branch_i = 1; addr_i = 32'h600; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hBAD;
    #1;
    chk("brrv_req", {31'd0, instr_req_o}, 1);
    chk("brrv_addr", instr_addr_o, 32'h600);
    @(negedge clk);
    branch_i = 0; instr_rvalid_i = 0; instr_gnt_i = 1;
    #1;
    chk("brrv_dropped", {31'd0, valid_o}, 0);
    chk("brrv_req_addr", instr_addr_o, 32'h600);
    @(negedge clk);
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h600D;
    @(negedge clk);
    instr_rvalid_i = 0;
    #1;
    chk("brrv_valid", {31'd0, valid_o}, 1);
    chk("brrv_rdata", rdata_o, 32'h600D);
    chk("brrv_addr_o", addr_o, 32'h600);

    // Asynchronous reset in WAIT_RVALID, then a stray rvalid after release.
    do_reset();
    @(negedge clk);
    req_i = 1; branch_i = 1; addr_i = 32'h700; instr_gnt_i = 1;
    @(negedge clk);
    branch_i = 0; instr_gnt_i = 0;
    #1;
    rst_n = 0;
    #1;
    chk("arst_instr_req", {31'd0, instr_req_o}, 0);
    chk("arst_instr_addr", instr_addr_o, 0);
    chk("arst_busy", {31'd0, busy_o}, 0);
    chk("arst_valid", {31'd0, valid_o}, 0);
    chk("arst_rdata", rdata_o, 0);
    @(negedge clk);
    rst_n = 1; req_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h5555;
    @(negedge clk);
    instr_rvalid_i = 0;
    #1;
    chk("stray_valid", {31'd0, valid_o}, 0);
    chk("stray_busy", {31'd0, busy_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
